// File: rtl/me_pkg.sv
// Shared constants and pixel type for the motion-estimation frame memory.
// Search-window range checking lives here so every user applies the same rule.
package me_pkg;

    localparam int DATA_W     = 8;
    localparam int REF_DIM    = 16;
    localparam int SRCH_DIM   = 31;
    localparam int REF_DEPTH  = REF_DIM * REF_DIM;
    localparam int SRCH_DEPTH = SRCH_DIM * SRCH_DIM;
    localparam int REF_AW     = 8;
    localparam int SRCH_AW    = 10;

    typedef logic [DATA_W-1:0] pixel_t;

    function automatic logic srch_in_range(input logic [SRCH_AW-1:0] addr);
        return addr < SRCH_AW'(SRCH_DEPTH);
    endfunction

endpackage

// File: rtl/me_sync_ram.sv
// Single-write, multi-read synchronous RAM with registered read-first outputs.
// Addresses at or beyond DEPTH read as zero and never write.
module me_sync_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = 8,
    parameter int NUM_RD = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en_i,
    input  logic [AW-1:0]                  wr_addr_i,
    input  logic [DATA_W-1:0]              wr_data_i,
    input  logic [NUM_RD-1:0][AW-1:0]      rd_addr_i,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_o
);

    logic [DATA_W-1:0]             mem_q [DEPTH];
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_q;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_d;

    // Widened by one bit so a power-of-two DEPTH does not wrap to zero.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return {1'b0, addr} < (AW+1)'(DEPTH);
    endfunction

    always_comb begin
        rd_data_d = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (in_range(rd_addr_i[p])) begin
                rd_data_d[p] = mem_q[rd_addr_i[p]];
            end
        end
    end

    // NOTE: the array itself is deliberately not reset so it maps onto block RAM
    // and survives a mid-operation reset; only the read registers are cleared.
    always_ff @(posedge clk) begin
        if (!reset && wr_en_i && in_range(wr_addr_i)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // NOTE: non-blocking update of both the array and the read register is what
    // makes a same-edge read see the old contents (read-first).
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/me_frame_memory.sv
// Reference block plus search window storage for full-search motion estimation.
// Steers the loader into one of two RAMs and tracks out-of-range search accesses.
module me_frame_memory
    import me_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic               load_sel,
    input  logic [SRCH_AW-1:0] load_addr,
    input  pixel_t             load_data,
    input  logic [REF_AW-1:0]  address_ref,
    input  logic [SRCH_AW-1:0] address_search1,
    input  logic [SRCH_AW-1:0] address_search2,
    output pixel_t             ref_data,
    output pixel_t             search_data1,
    output pixel_t             search_data2,
    output logic               addr_error
);

    logic              ref_we;
    logic              srch_we;
    logic [1:0][DATA_W-1:0] srch_rd;
    logic              err_seen;
    logic              addr_error_q;
    logic              addr_error_d;

    assign ref_we  = load_en && !load_sel;
    assign srch_we = load_en &&  load_sel;

    me_sync_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (REF_DEPTH),
        .AW     (REF_AW),
        .NUM_RD (1)
    ) u_ref_ram (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (ref_we),
        .wr_addr_i (load_addr[REF_AW-1:0]),
        .wr_data_i (load_data),
        .rd_addr_i (address_ref),
        .rd_data_o (ref_data)
    );

    me_sync_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (SRCH_DEPTH),
        .AW     (SRCH_AW),
        .NUM_RD (2)
    ) u_srch_ram (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (srch_we),
        .wr_addr_i (load_addr),
        .wr_data_i (load_data),
        .rd_addr_i ({address_search2, address_search1}),
        .rd_data_o (srch_rd)
    );

    assign search_data1 = srch_rd[0];
    assign search_data2 = srch_rd[1];

    // Reference addresses decode fully, so only search-side accesses can be bad.
    always_comb begin
        err_seen     = !srch_in_range(address_search1)
                    || !srch_in_range(address_search2)
                    || (srch_we && !srch_in_range(load_addr));
        addr_error_d = addr_error_q | err_seen;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_error_q <= 1'b0;
        end else begin
            addr_error_q <= addr_error_d;
        end
    end

    assign addr_error = addr_error_q;

endmodule

// File: tb/tb_me_frame_memory.sv
// Scoreboard bench: stimulus pushes expected outputs from an array model,
// a monitor pops one entry per clock edge and compares against the DUT.
module tb_me_frame_memory;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_en;
    logic       load_sel;
    logic [9:0] load_addr;
    logic [7:0] load_data;
    logic [7:0] address_ref;
    logic [9:0] address_search1;
    logic [9:0] address_search2;
    logic [7:0] ref_data;
    logic [7:0] search_data1;
    logic [7:0] search_data2;
    logic       addr_error;

    me_frame_memory dut (
        .clk             (clk),
        .reset           (reset),
        .load_en         (load_en),
        .load_sel        (load_sel),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .address_ref     (address_ref),
        .address_search1 (address_search1),
        .address_search2 (address_search2),
        .ref_data        (ref_data),
        .search_data1    (search_data1),
        .search_data2    (search_data2),
        .addr_error      (addr_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit chk_r;
        bit chk_s1;
        bit chk_s2;
        int r;
        int s1;
        int s2;
        bit err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: plain arrays plus "has been written" flags.
    int ref_m  [256];
    bit ref_k  [256];
    int srch_m [961];
    bit srch_k [961];
    bit err_m;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs after the coming edge,
    // then apply that edge's write to the model.
    task automatic step(input bit rst, input bit len, input bit lsel, input int laddr,
                        input int ldata, input int ar, input int a1, input int a2);
        exp_t e;
        reset           = rst;
        load_en         = len;
        load_sel        = lsel;
        load_addr       = 10'(laddr);
        load_data       = 8'(ldata);
        address_ref     = 8'(ar);
        address_search1 = 10'(a1);
        address_search2 = 10'(a2);
        e = '{default: 0};
        if (rst) begin
            e.chk_r  = 1;
            e.chk_s1 = 1;
            e.chk_s2 = 1;
            err_m    = 0;
        end else begin
            e.chk_r = ref_k[ar];
            e.r     = ref_m[ar];
            if (a1 >= 961) e.chk_s1 = 1;
            else begin e.chk_s1 = srch_k[a1]; e.s1 = srch_m[a1]; end
            if (a2 >= 961) e.chk_s2 = 1;
            else begin e.chk_s2 = srch_k[a2]; e.s2 = srch_m[a2]; end
            if (a1 >= 961 || a2 >= 961 || (len && lsel && laddr >= 961)) err_m = 1;
            if (len && !lsel) begin
                ref_m[laddr % 256] = ldata % 256;
                ref_k[laddr % 256] = 1;
            end else if (len && lsel && laddr < 961) begin
                srch_m[laddr] = ldata % 256;
                srch_k[laddr] = 1;
            end
        end
        e.err = err_m;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int ar, input int a1, input int a2);
        step(0, 0, 0, 0, 0, ar, a1, a2);
    endtask

    always @(posedge clk) begin : monitor
        exp_t m;
        #1;
        if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            if (m.chk_r)  check("ref_data",     32'(ref_data),     32'(m.r));
            if (m.chk_s1) check("search_data1", 32'(search_data1), 32'(m.s1));
            if (m.chk_s2) check("search_data2", 32'(search_data2), 32'(m.s2));
            check("addr_error", 32'(addr_error), 32'(m.err));
        end
    end

    initial begin
        err_m = 0;
        // 1. reset held two cycles
        step(1, 0, 0, 0, 0, 5, 0, 0);
        step(1, 0, 0, 0, 0, 5, 0, 0);
        idle(5, 0, 0);

        // 2. reference load, high address bits must be ignored
        for (int i = 0; i < 256; i++)
            step(0, 1, 0, i + 256 * $urandom_range(0, 3), i,
                 $urandom_range(0, 255), $urandom_range(0, 960), $urandom_range(0, 960));
        idle(17, 0, 0);
        idle(255, 0, 0);

        // 3. search load and dual-port reads
        for (int i = 0; i < 961; i++)
            step(0, 1, 1, i, i % 256,
                 $urandom_range(0, 255), $urandom_range(0, 960), $urandom_range(0, 960));
        idle(0, 0, 960);
        idle(0, 500, 500);

        // 4. read-first collision
        step(0, 1, 1, 100, 7, 0, 0, 0);
        step(0, 1, 1, 100, 8'hAA, 0, 100, 100);
        idle(0, 100, 100);

        // 5. out-of-range read and write, sticky until reset
        idle(0, 10, 961);
        step(0, 1, 1, 1000, 8'h55, 0, 20, 30);
        idle(0, 1, 2);
        idle(0, 3, 4);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 5, 6);

        // 6. mid-operation reset preserves contents
        for (int i = 0; i < 3; i++) idle(40 + i, 200 + i, 700 + i);
        step(1, 0, 0, 0, 0, 40, 200, 700);
        for (int i = 0; i < 3; i++) idle(40 + i, 200 + i, 700 + i);

        // Random traffic with occasional bad addresses and periodic resets.
        for (int i = 0; i < 600; i++) begin
            int la, a1, a2;
            la = ($urandom_range(0, 19) == 0) ? $urandom_range(961, 1023) : $urandom_range(0, 960);
            a1 = ($urandom_range(0, 49) == 0) ? $urandom_range(961, 1023) : $urandom_range(0, 960);
            a2 = ($urandom_range(0, 49) == 0) ? $urandom_range(961, 1023) : $urandom_range(0, 960);
            step((i % 150) == 149, $urandom_range(0, 1), $urandom_range(0, 1), la,
                 $urandom_range(0, 255), $urandom_range(0, 255), a1, a2);
        end
        idle(0, 0, 0);

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
